fft_frame_sink: RTL
===================

// Module: fft_frame_sink
// PURPOSE
//  AXI4-Stream sink for the FFT core's output frame (result side of the FFT handshake).
//  Captures one POINTS-bin frame into an internal buffer, addressing each write by the bin index carried in tuser.
//  Checks frame length and replays the bins in natural order (0..POINTS-1) as a ready/valid stream of split real/imag words.
//  That stream feeds the power/dB stage in the clk_24M domain.
// PARAMETERS
//  POINTS   1024  bins per frame (power of two)
//  ADDR_W   10    log2(POINTS)
//  DATA_W   48    input beat width: [DATA_W/2-1:0]=real, [DATA_W-1:DATA_W/2]=imag
//  TUSER_W  24    input tuser width; bin index = tuser[ADDR_W-1:0]
// PORTS
//  clk          in   1         processing clock (clk_24M)
//  rst_n        in   1         asynchronous active-low reset
//  arm          in   1         1-cycle pulse: accept the next frame (honoured in IDLE only)
//  s_tdata      in   DATA_W    FFT result beat
//  s_tuser      in   TUSER_W   FFT sideband; low ADDR_W bits = bin index
//  s_tvalid     in   1         beat valid
//  s_tlast      in   1         last beat of frame
//  s_tready     out  1         1 only in CAPTURE and FLUSH
//  m_real       out  DATA_W/2  signed real part of bin m_index
//  m_imag       out  DATA_W/2  signed imag part of bin m_index
//  m_index      out  ADDR_W    bin number, 0..POINTS-1
//  m_valid      out  1         output beat valid
//  m_last       out  1         high with m_index==POINTS-1
//  m_ready      in   1         downstream accept
//  frame_done   out  1         1-cycle pulse after the last output beat is accepted
//  err_len      out  1         1-cycle pulse: frame had tlast at a beat count other than POINTS
//  overrun      out  1         sticky: s_tvalid seen while s_tready=0; cleared by accepted arm
//  busy         out  1         state != IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; all outputs 0; counters 0. Buffer contents are not reset.
//  Handshake: a beat transfers when valid&&ready on a clk edge, on both interfaces.
//  IDLE:
//   - arm -> CAPTURE; beat_cnt=0; overrun cleared.
//   - s_tvalid sets overrun. The upstream core cannot stall, so that beat is lost.
//  CAPTURE:
//   - Each beat writes buf[s_tuser[ADDR_W-1:0]] = s_tdata; beat_cnt++.
//   - tlast with beat_cnt==POINTS-1 -> READOUT.
//   - tlast earlier -> err_len pulse, then IDLE.
//   - Beat POINTS-1 without tlast -> err_len pulse, then FLUSH.
//  FLUSH: s_tready=1; beats are discarded; tlast -> IDLE.
//  READOUT:
//   - Synchronous-read buffer; read address rd_addr counts 0..POINTS-1.
//   - First m_valid exactly 2 cycles after entering READOUT.
//   - With m_ready held 1, one beat per cycle, so a frame drains in POINTS+2 cycles.
//   - While m_valid && !m_ready: m_real, m_imag, m_index, m_last are held stable. No beat is dropped or duplicated.
//   - 1-entry skid register absorbs the in-flight read when m_ready drops.
//   - Final accept (m_last && m_ready) -> m_valid=0; frame_done pulses the next cycle; state -> IDLE.
//  arm outside IDLE: ignored. m_valid is never 1 outside READOUT.
//  Duplicate tuser indices within a frame: last write wins; length counting is unaffected.
//  Simultaneous tlast and error in one beat (short frame): err_len pulses once only.
//  rst_n low mid-operation: immediate IDLE, outputs 0; the partial frame is discarded.
// TESTING
//  T1 reset: assert rst_n=0 mid-READOUT -> m_valid, busy, s_tready=0 within the same cycle; IDLE after release.
//  T2 full frame:
//   - Stimulus: arm, then 1024 beats with bit-reversed tuser k, s_tdata={imag=k, real=-k}, tlast on beat 1024.
//   - Response: m_index 0..1023 in order; m_real=-m_index, m_imag=m_index; m_last at 1023; frame_done once.
//  T3 backpressure: T2 with m_ready random 50% -> identical output sequence; outputs stable while stalled; no gaps in index.
//  T4 short frame: tlast on beat 100 -> err_len one pulse; state IDLE; m_valid never asserted.
//  T5 long frame: 1030 beats, tlast on 1030 -> err_len at beat 1024; beats 1025-1030 accepted, discarded; then IDLE.
//  T6 overrun: s_tvalid=1 for 3 cycles in IDLE -> overrun=1 and stays set; next arm clears it; T2 then passes.

Source files
------------

// File: rtl/fft_frame_sink_if.sv
// Stream bundle for fft_frame_sink: the FFT result input (s_*) and the natural-order
// bin output (m_*). A beat moves on a clk edge only while its valid and ready are both 1.
interface fft_frame_sink_if #(
  parameter int DATA_W  = 48,
  parameter int TUSER_W = 24,
  parameter int ADDR_W  = 10
);
  logic [DATA_W-1:0]          s_tdata;
  logic [TUSER_W-1:0]         s_tuser;
  logic                       s_tvalid;
  logic                       s_tlast;
  logic                       s_tready;
  logic signed [DATA_W/2-1:0] m_real;
  logic signed [DATA_W/2-1:0] m_imag;
  logic [ADDR_W-1:0]          m_index;
  logic                       m_valid;
  logic                       m_last;
  logic                       m_ready;

  // slave: the frame sink itself (consumes s_*, produces m_*)
  modport slave (
    input  s_tdata, s_tuser, s_tvalid, s_tlast, m_ready,
    output s_tready, m_real, m_imag, m_index, m_valid, m_last
  );

  // master: the surrounding FFT core and power/dB stage
  modport master (
    output s_tdata, s_tuser, s_tvalid, s_tlast, m_ready,
    input  s_tready, m_real, m_imag, m_index, m_valid, m_last
  );
endinterface

// File: rtl/fft_frame_sink.sv
// Captures one FFT result frame indexed by tuser bin number, checks its length,
// and replays it in natural bin order as a ready/valid stream of real/imag words.
module fft_frame_sink #(
  parameter int POINTS  = 1024,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 48,
  parameter int TUSER_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  fft_frame_sink_if.slave   bus,
  output logic              frame_done,
  output logic              err_len,
  output logic              overrun,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int HALF = DATA_W / 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_FLUSH   = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              err_set;
  logic              s_fire;
  logic              last_beat;
  logic              final_accept;
  logic              out_free;
  logic              rd_en;
  logic [ADDR_W:0]   rd_cnt_q;

  // Read pipeline: P holds the synchronous RAM output, skid catches it when m_ready drops.
  logic              p_valid_q;
  logic [DATA_W-1:0] p_data_q;
  logic [ADDR_W-1:0] p_idx_q;
  logic              skid_valid_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [ADDR_W-1:0] skid_idx_q;

  logic [DATA_W-1:0] mem [POINTS];

  logic unused_tuser;
  assign unused_tuser = ^bus.s_tuser[TUSER_W-1:ADDR_W];

  assign bus.s_tready = (state_q == S_CAPTURE) || (state_q == S_FLUSH);
  assign busy         = (state_q != S_IDLE);
  assign state_dbg    = state_q;
  assign s_fire       = bus.s_tvalid && bus.s_tready;
  assign last_beat    = (beat_cnt_q == ADDR_W'(POINTS - 1));
  assign final_accept = bus.m_valid && bus.m_last && bus.m_ready;
  assign out_free     = !bus.m_valid || bus.m_ready;

  // Only issue a read if whatever lands in P next cycle is guaranteed a free slot.
  assign rd_en = (state_q == S_READOUT) && !rd_cnt_q[ADDR_W] && !skid_valid_q &&
                 !(p_valid_q && bus.m_valid && !bus.m_ready);

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    err_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d    = S_CAPTURE;
          beat_cnt_d = '0;
        end
      end
      S_CAPTURE: begin
        if (s_fire) begin
          beat_cnt_d = beat_cnt_q + ADDR_W'(1);
          if (bus.s_tlast) begin
            if (last_beat) begin
              state_d = S_READOUT;
            end else begin
              err_set = 1'b1;
              state_d = S_IDLE;
            end
          end else if (last_beat) begin
            err_set = 1'b1;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (s_fire && bus.s_tlast) state_d = S_IDLE;
      end
      S_READOUT: begin
        if (final_accept) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame buffer: no reset, last write to a bin wins.
  always_ff @(posedge clk) begin
    if (state_q == S_CAPTURE && s_fire) mem[bus.s_tuser[ADDR_W-1:0]] <= bus.s_tdata;
    if (rd_en) p_data_q <= mem[rd_cnt_q[ADDR_W-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      beat_cnt_q   <= '0;
      err_len      <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
      rd_cnt_q     <= '0;
      p_valid_q    <= 1'b0;
      p_idx_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_idx_q   <= '0;
      bus.m_valid  <= 1'b0;
      bus.m_last   <= 1'b0;
      bus.m_index  <= '0;
      bus.m_real   <= '0;
      bus.m_imag   <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      err_len    <= err_set;
      frame_done <= final_accept;

      // A lost beat outweighs a same-cycle arm.
      if (bus.s_tvalid && !bus.s_tready) overrun <= 1'b1;
      else if (state_q == S_IDLE && arm) overrun <= 1'b0;

      if (state_q != S_READOUT) begin
        rd_cnt_q     <= '0;
        p_valid_q    <= 1'b0;
        skid_valid_q <= 1'b0;
        bus.m_valid  <= 1'b0;
        bus.m_last   <= 1'b0;
      end else begin
        p_valid_q <= rd_en;
        if (rd_en) begin
          rd_cnt_q <= rd_cnt_q + (ADDR_W + 1)'(1);
          p_idx_q  <= rd_cnt_q[ADDR_W-1:0];
        end
        if (out_free) begin
          if (skid_valid_q) begin
            bus.m_valid  <= 1'b1;
            bus.m_real   <= skid_data_q[HALF-1:0];
            bus.m_imag   <= skid_data_q[DATA_W-1:HALF];
            bus.m_index  <= skid_idx_q;
            bus.m_last   <= (skid_idx_q == ADDR_W'(POINTS - 1));
            skid_valid_q <= p_valid_q;
            skid_data_q  <= p_data_q;
            skid_idx_q   <= p_idx_q;
          end else if (p_valid_q) begin
            bus.m_valid <= 1'b1;
            bus.m_real  <= p_data_q[HALF-1:0];
            bus.m_imag  <= p_data_q[DATA_W-1:HALF];
            bus.m_index <= p_idx_q;
            bus.m_last  <= (p_idx_q == ADDR_W'(POINTS - 1));
          end else begin
            bus.m_valid <= 1'b0;
            bus.m_last  <= 1'b0;
          end
        end else if (p_valid_q) begin
          skid_valid_q <= 1'b1;
          skid_data_q  <= p_data_q;
          skid_idx_q   <= p_idx_q;
        end
      end
    end
  end

endmodule
